// File: rtl/scale_loop_scheduler.sv
// Frame-level sequencer for the scale-parameter generator: clears it, steps it
// one scale at a time, and hands every scale that still covers the window to the detector.
module scale_loop_scheduler #(
    parameter int W_BITS   = 10,
    parameter int H_BITS   = 10,
    parameter int WIN_BITS = 16,
    parameter int TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                frame_start,
    input  logic                frame_abort,
    input  logic [WIN_BITS-1:0] cfg_win_size,
    input  logic [7:0]          cfg_max_scales,
    output logic                sp_resetn,
    output logic                sp_start,
    output logic                sp_taken,
    input  logic                sp_ready,
    input  logic                sp_done,
    input  logic [W_BITS-1:0]   sp_scale_w,
    input  logic [H_BITS-1:0]   sp_scale_h,
    output logic                scale_valid,
    input  logic                scale_ready,
    output logic [W_BITS-1:0]   scale_w,
    output logic [H_BITS-1:0]   scale_h,
    output logic [7:0]          scale_idx,
    input  logic                det_done,
    output logic                busy,
    output logic                frame_done,
    output logic                timeout_err
);
    localparam int TW  = $clog2(TIMEOUT) + 1;
    localparam int CW0 = (W_BITS > H_BITS) ? W_BITS : H_BITS;
    localparam int CW  = (CW0 > WIN_BITS) ? CW0 : WIN_BITS;

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_WAIT_RDY, S_START, S_WAIT_DONE,
        S_CHECK, S_OFFER, S_RUN, S_TAKE, S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [WIN_BITS-1:0] win_q, win_d;
    logic [7:0]          max_q, max_d;
    logic [7:0]          issued_q, issued_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [W_BITS-1:0]   scale_w_q, scale_w_d;
    logic [H_BITS-1:0]   scale_h_q, scale_h_d;
    logic [7:0]          scale_idx_q, scale_idx_d;
    logic                timeout_err_q, timeout_err_d;
    logic                sp_resetn_q, sp_resetn_d;
    logic                sp_start_q, sp_start_d;
    logic                sp_taken_q, sp_taken_d;
    logic                scale_valid_q, scale_valid_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                clr_pulse, fail_take, fin_exit, fits;

    assign fits = (CW'(sp_scale_w) >= CW'(win_q)) && (CW'(sp_scale_h) >= CW'(win_q));

    always_comb begin
        state_d       = state_q;
        win_d         = win_q;
        max_d         = max_q;
        issued_d      = issued_q;
        tcnt_d        = tcnt_q;
        scale_w_d     = scale_w_q;
        scale_h_d     = scale_h_q;
        scale_idx_d   = scale_idx_q;
        timeout_err_d = timeout_err_q;
        clr_pulse     = 1'b0;
        fail_take     = 1'b0;
        fin_exit      = 1'b0;
        case (state_q)
            S_IDLE: if (frame_start) begin
                win_d         = cfg_win_size;
                max_d         = cfg_max_scales;
                issued_d      = 8'd0;
                timeout_err_d = 1'b0;
                state_d       = S_CLR;
            end
            S_CLR:      state_d = S_WAIT_RDY;
            S_WAIT_RDY: if (sp_ready) state_d = (issued_q == max_q) ? S_FIN : S_START;
            S_START: begin
                tcnt_d  = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                tcnt_d = tcnt_q + TW'(1);
                if (sp_done) begin
                    state_d = S_CHECK;
                end else if (tcnt_d == TW'(TIMEOUT - 1)) begin
                    // Generator hung: flag it, clear it, and drop the frame silently.
                    timeout_err_d = 1'b1;
                    clr_pulse     = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_CHECK: if (fits) begin
                scale_w_d   = sp_scale_w;
                scale_h_d   = sp_scale_h;
                scale_idx_d = issued_q;
                state_d     = S_OFFER;
            end else begin
                fail_take = 1'b1;
                state_d   = S_FIN;
            end
            S_OFFER: if (scale_ready) begin
                issued_d = (issued_q == 8'hFF) ? issued_q : issued_q + 8'd1;
                state_d  = S_RUN;
            end
            S_RUN:  if (det_done) state_d = S_TAKE;
            S_TAKE: state_d = S_WAIT_RDY;
            S_FIN: begin
                fin_exit = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every other same-cycle event, including the offer handshake.
        if (frame_abort && state_q != S_IDLE) begin
            state_d       = S_IDLE;
            clr_pulse     = 1'b1;
            fail_take     = 1'b0;
            fin_exit      = 1'b0;
            issued_d      = issued_q;
            scale_w_d     = scale_w_q;
            scale_h_d     = scale_h_q;
            scale_idx_d   = scale_idx_q;
            timeout_err_d = timeout_err_q;
        end

        sp_resetn_d   = !(state_d == S_CLR || clr_pulse);
        sp_start_d    = (state_d == S_START);
        sp_taken_d    = (state_d == S_TAKE) || fail_take;
        scale_valid_d = (state_d == S_OFFER);
        busy_d        = (state_d != S_IDLE);
        frame_done_d  = fin_exit;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            win_q         <= '0;
            max_q         <= '0;
            issued_q      <= '0;
            tcnt_q        <= '0;
            scale_w_q     <= '0;
            scale_h_q     <= '0;
            scale_idx_q   <= '0;
            timeout_err_q <= 1'b0;
            sp_resetn_q   <= 1'b0;
            sp_start_q    <= 1'b0;
            sp_taken_q    <= 1'b0;
            scale_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            max_q         <= max_d;
            issued_q      <= issued_d;
            tcnt_q        <= tcnt_d;
            scale_w_q     <= scale_w_d;
            scale_h_q     <= scale_h_d;
            scale_idx_q   <= scale_idx_d;
            timeout_err_q <= timeout_err_d;
            sp_resetn_q   <= sp_resetn_d;
            sp_start_q    <= sp_start_d;
            sp_taken_q    <= sp_taken_d;
            scale_valid_q <= scale_valid_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign sp_resetn   = sp_resetn_q;
    assign sp_start    = sp_start_q;
    assign sp_taken    = sp_taken_q;
    assign scale_valid = scale_valid_q;
    assign scale_w     = scale_w_q;
    assign scale_h     = scale_h_q;
    assign scale_idx   = scale_idx_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_err_q;
endmodule

// File: doc/scale_loop_scheduler.md
Name: scale_loop_scheduler

Overview:
- Frame-level controller for the scale-parameter generator.
- Per frame: clears the generator, then repeatedly starts it and checks each scaled image size against the window size. Each surviving scale goes to the detector, which must finish before the next scale is requested.
- Sits between the frame front-end and the generator/detector pair. Ends the frame when the scaled image no longer fits the window, the scale limit is hit, the frame is aborted, or a timeout occurs.

Parameters:
- W_BITS, 10, scaled/base width bits (matches image cache row bits)
- H_BITS, 10, scaled/base height bits (matches image cache column bits)
- WIN_BITS, 16, window-size bits
- TIMEOUT, 64, max cycles from sp_start to sp_done before error

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- frame_start  in  1  pulse; begins frame (ignored unless idle)
- frame_abort  in  1  pulse; abandons current frame
- cfg_win_size  in  WIN_BITS  window size, sampled on accepted frame_start
- cfg_max_scales  in  8  scale limit, sampled on accepted frame_start
- sp_resetn  out  1  synchronous active-low clear to generator
- sp_start  out  1  one-cycle start to generator
- sp_taken  out  1  one-cycle release to generator
- sp_ready  in  1  generator idle/ready
- sp_done  in  1  generator result valid (level)
- sp_scale_w  in  W_BITS  generator scaled width
- sp_scale_h  in  H_BITS  generator scaled height
- scale_valid  out  1  scale offered to detector
- scale_ready  in  1  detector accepts offered scale
- scale_w  out  W_BITS  offered width, registered
- scale_h  out  H_BITS  offered height, registered
- scale_idx  out  8  0-based index of offered scale
- det_done  in  1  pulse; detector finished current scale
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at normal frame end
- timeout_err  out  1  sticky; cleared by next accepted frame_start

Behaviour:
- Reset (async, resetn=0):
  - state IDLE, sp_resetn=0 while reset is asserted, then 1.
  - All other outputs 0; scale_w/h/idx 0; internal counters 0.
- States: IDLE, CLR, WAIT_RDY, START, WAIT_DONE, CHECK, OFFER, RUN, TAKE, FIN.
- IDLE: on frame_start, latch cfg_*, clear timeout_err and issued counter, then go to CLR.
- CLR: sp_resetn=0 for exactly one cycle, clearing the generator's accumulated scale. Then go to WAIT_RDY.
- WAIT_RDY: wait for sp_ready=1. If issued count == latched max_scales, go to FIN; otherwise go to START.
- START: sp_start=1 for one cycle. Load the timeout counter with 0. Go to WAIT_DONE.
- WAIT_DONE:
  - Increment the timeout counter each cycle.
  - sp_done=1 goes to CHECK.
  - If the counter reaches TIMEOUT-1 without sp_done: set timeout_err, pulse sp_resetn low one cycle, go to IDLE. No frame_done in this case.
- CHECK: compare sp_scale_w >= win_size AND sp_scale_h >= win_size, zero-extended to max width.
  - Pass: register scale_w/h, set scale_idx = issued count, go to OFFER.
  - Fail: pulse sp_taken, go to FIN.
- OFFER: hold scale_valid=1 with stable scale_w/h/idx until scale_ready=1. On the handshake cycle, increment issued count and go to RUN.
- RUN: scale_valid=0. On det_done go to TAKE. det_done in any other state is ignored.
- TAKE: sp_taken=1 for one cycle, then go to WAIT_RDY.
- FIN: frame_done=1 for one cycle, then go to IDLE.
- Abort:
  - frame_abort in any non-IDLE state forces IDLE next cycle, dropping scale_valid immediately at that edge.
  - Pulse sp_resetn low for that one cycle. No frame_done; issued count is held.
  - Abort has priority over every same-cycle event, including frame_start, scale_ready and det_done.
  - Abort in IDLE has no effect.
- frame_start while busy is ignored.
- cfg_max_scales=0: the frame runs CLR, WAIT_RDY, FIN with no sp_start.
- Issued count saturates at 255.
- All outputs are registered.

Test Plan:
- Reset mid-frame: assert resetn=0 while in OFFER -> scale_valid=0, busy=0 immediately (async); after release, IDLE with all outputs 0.
- Normal frame: win=24, max=10; generator returns widths 320, 256, 205, 20 -> exactly 3 scale_valid handshakes with idx 0,1,2 and w 320,256,205. On the 4th result: sp_taken, then frame_done one cycle later, 4 sp_start pulses total.
- Limit stop: win=24, max=2, sizes always 320x240 -> 2 scales offered, then FIN without a third sp_start.
- Backpressure: hold scale_ready=0 for 7 cycles in OFFER -> scale_valid and scale_w/h/idx stable all 7 cycles; det_done during OFFER ignored.
- Timeout: TIMEOUT=64, never assert sp_done -> sp_resetn low exactly 64 cycles after sp_start, timeout_err=1, busy=0, no frame_done. The next frame_start clears timeout_err.
- Abort collision: frame_abort and scale_ready in the same OFFER cycle -> no idx increment, IDLE next cycle, one-cycle sp_resetn=0, no frame_done.
